// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: Avalon-MM slave that buffers 16-bit signed PCM
// samples in a FIFO, pops one per programmable sample period and renders the
// current sample on a single-pin PWM DAC. Raises a level irq on low-water or
// underrun so software can refill the FIFO.
module audio_sample_streamer #(
   parameter int DEPTH_LOG2   = 6,
   parameter int PWM_BITS     = 8,
   parameter int DIV_RESET    = 1133,
   parameter int THRESH_RESET = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        sample_tick,
   output logic        pwm_out
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   logic [15:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]         r_level, r_thresh;
   logic                  r_underrun, r_overflow, r_irq_en, r_run;
   logic                  r_tick, r_irq, r_pwm;
   logic [15:0]           r_div, r_cnt, r_sample, r_readdata;
   logic [PWM_BITS-1:0]   r_pwm_cnt, r_duty;

   logic w_wr, w_wr_status, w_wr_ctrl, w_wr_div, w_wr_data, w_wr_thr;
   logic w_flush, w_run_next, w_stop, w_empty, w_full, w_low;
   logic w_pop, w_push, w_underrun_set, w_overflow_set, w_tick_next;
   logic [15:0] w_div_next, w_cnt_next, w_rd_mux;
   logic [PWM_BITS-1:0] w_duty_src;

   // Bus decode
   assign w_wr        = chipselect && !write_n;
   assign w_wr_status = w_wr && (address == 3'd0);
   assign w_wr_ctrl   = w_wr && (address == 3'd1);
   assign w_wr_div    = w_wr && (address == 3'd2);
   assign w_wr_data   = w_wr && (address == 3'd3);
   assign w_wr_thr    = w_wr && (address == 3'd5);

   assign w_flush    = w_wr_ctrl && writedata[2];
   assign w_run_next = w_wr_ctrl ? writedata[1] : r_run;
   assign w_div_next = w_wr_div ? writedata : r_div;
   // Stopping parks the stream: the output sample goes silent and the
   // FIFO is left exactly as it was, even if a tick lands in that cycle.
   assign w_stop     = r_run && !w_run_next;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == LW'(DEPTH));
   assign w_low   = (r_level <= r_thresh);

   // r_tick is high exactly when the running counter sits at zero, so it is
   // both the external strobe and the internal pop event.
   assign w_pop          = r_tick && !w_empty && !w_flush && !w_stop;
   assign w_underrun_set = r_tick &&  w_empty && !w_flush && !w_stop;
   // A pop in the same cycle frees a slot, so a push to a full FIFO succeeds.
   assign w_push         = w_wr_data && !w_flush && (!w_full || w_pop);
   assign w_overflow_set = w_wr_data && !w_flush && w_full && !w_pop;

   // Offset-binary duty source: invert the sign bit, keep the top bits
   assign w_duty_src = {~r_sample[15], r_sample[14 -: PWM_BITS-1]};

   // Next divider count; the tick flag is precomputed so it is a clean flop
   always_comb begin
      w_cnt_next = r_cnt;
      if (!r_run)
         w_cnt_next = w_div_next;
      else if (r_cnt == 16'd0)
         w_cnt_next = r_div;
      else
         w_cnt_next = r_cnt - 16'd1;
   end
   assign w_tick_next = w_run_next && (w_cnt_next == 16'd0);

   // Register read mux
   always_comb begin
      w_rd_mux = '0;
      case (address)
         3'd0: w_rd_mux[4:0] = {w_empty, w_full, w_low, r_overflow, r_underrun};
         3'd1: w_rd_mux[1:0] = {r_run, r_irq_en};
         3'd2: w_rd_mux = r_div;
         3'd3: w_rd_mux = r_sample;
         3'd4: w_rd_mux[LW-1:0] = r_level;
         3'd5: w_rd_mux[LW-1:0] = r_thresh;
         default: w_rd_mux = '0;
      endcase
   end

   // FIFO storage: write port only, contents are not reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= writedata;
   end

   // FIFO pointers and fill level; flush overrides any push or pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         if (w_push && !w_pop)      r_level <= r_level + LW'(1);
         else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      end
   end

   // Control, divider and threshold registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
         r_run    <= 1'b0;
         r_div    <= 16'(DIV_RESET);
         r_thresh <= LW'(THRESH_RESET);
      end else begin
         r_run <= w_run_next;
         if (w_wr_ctrl) r_irq_en <= writedata[0];
         if (w_wr_div)  r_div    <= writedata;
         if (w_wr_thr)  r_thresh <= writedata[LW-1:0];
      end
   end

   // Sample-rate down-counter and tick strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= 16'(DIV_RESET);
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_tick <= w_tick_next;
      end
   end

   // Current output sample: zeroed on stop, loaded from the head on pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_sample <= '0;
      else if (w_stop) r_sample <= '0;
      else if (w_pop)  r_sample <= r_mem[r_rd_ptr];
   end

   // Sticky status flags: a set event beats a clearing write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_underrun <= w_underrun_set || (r_underrun && !w_wr_status);
         r_overflow <= w_overflow_set || (r_overflow && !w_wr_status);
      end
   end

   // Registered read data and interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_readdata <= w_rd_mux;
         r_irq      <= r_irq_en && (r_underrun || w_low);
      end
   end

   // PWM: duty only changes at the frame wrap to avoid partial-frame glitches
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_cnt <= '0;
         r_duty    <= PWM_BITS'(1) << (PWM_BITS-1);
         r_pwm     <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
         if (r_pwm_cnt == '1) r_duty <= w_duty_src;
         r_pwm <= (r_pwm_cnt < r_duty);
      end
   end

   assign readdata    = r_readdata;
   assign irq         = r_irq;
   assign sample_tick = r_tick;
   assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer: register tables plus
// hand-timed sequences for ticks, underrun, overflow, flush and reset.
module tb_audio_sample_streamer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        irq, sample_tick, pwm_out;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t rst_tab [8];
   vec_t rw_tab  [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   audio_sample_streamer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .irq         (irq),
      .sample_tick (sample_tick),
      .pwm_out     (pwm_out)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", nm, act);
      end
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic do_read(input logic [2:0] a, output logic [15:0] d);
      address = a; chipselect = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      d = readdata;
   endtask

   task automatic wait_tick(input int budget);
      int k = 0;
      while (!sample_tick && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!sample_tick) begin
         n_vec++;
         n_err++;
         $display("FAIL tick_timeout: no sample_tick within %0d clocks", budget);
      end
   endtask

   // Waits for any pending duty reload, then counts highs over one full frame
   task automatic measure_duty(output int highs);
      repeat (260) @(negedge clk);
      highs = 0;
      repeat (256) begin
         @(negedge clk);
         highs += int'(pwm_out);
      end
   endtask

   task automatic run_reset_table(input string tag);
      logic [15:0] rd;
      for (int i = 0; i < 8; i++) begin
         do_read(rst_tab[i].addr, rd);
         check($sformatf("%s_reg%0d", tag, rst_tab[i].addr), 32'(rd), 32'(rst_tab[i].exp));
      end
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] exp_s [3];
      int highs, t0, tprev;

      rst_tab[0] = '{1'b0, 3'd0, 16'h0000, 16'h0014};
      rst_tab[1] = '{1'b0, 3'd1, 16'h0000, 16'h0000};
      rst_tab[2] = '{1'b0, 3'd2, 16'h0000, 16'd1133};
      rst_tab[3] = '{1'b0, 3'd3, 16'h0000, 16'h0000};
      rst_tab[4] = '{1'b0, 3'd4, 16'h0000, 16'h0000};
      rst_tab[5] = '{1'b0, 3'd5, 16'h0000, 16'd16};
      rst_tab[6] = '{1'b0, 3'd6, 16'h0000, 16'h0000};
      rst_tab[7] = '{1'b0, 3'd7, 16'h0000, 16'h0000};

      rw_tab[0] = '{1'b1, 3'd2, 16'h1234, 16'h1234};
      rw_tab[1] = '{1'b1, 3'd5, 16'hFFFF, 16'h007F};
      rw_tab[2] = '{1'b1, 3'd1, 16'h0005, 16'h0001};
      rw_tab[3] = '{1'b1, 3'd1, 16'h0000, 16'h0000};
      rw_tab[4] = '{1'b1, 3'd6, 16'hBEEF, 16'h0000};
      rw_tab[5] = '{1'b1, 3'd5, 16'h0010, 16'h0010};
      rw_tab[6] = '{1'b1, 3'd2, 16'h0009, 16'h0009};
      rw_tab[7] = '{1'b1, 3'd0, 16'hFFFF, 16'h0014};

      exp_s[0] = 16'h7FFF; exp_s[1] = 16'h8000; exp_s[2] = 16'h0000;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_readdata", 32'(readdata), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_tick", 32'(sample_tick), 32'h0);
      check("rst_pwm", 32'(pwm_out), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      run_reset_table("reset");
      measure_duty(highs);
      check("duty_reset", 32'(highs), 32'd128);

      // Register write / read-back table
      for (int i = 0; i < 8; i++) begin
         if (rw_tab[i].we) do_write(rw_tab[i].addr, rw_tab[i].wdata);
         do_read(rw_tab[i].addr, rd);
         check($sformatf("rw%0d_reg%0d", i, rw_tab[i].addr), 32'(rd), 32'(rw_tab[i].exp));
      end

      // Three samples, DIVIDER=9, run
      do_write(3'd3, 16'h7FFF);
      do_write(3'd3, 16'h8000);
      do_write(3'd3, 16'h0000);
      do_read(3'd4, rd);
      check("level_3", 32'(rd), 32'd3);
      do_write(3'd1, 16'h0002);
      t0 = cyc;
      tprev = cyc;
      for (int k = 0; k < 3; k++) begin
         wait_tick(40);
         if (k == 0) check("first_tick_latency", 32'(cyc - t0 + 1), 32'd10);
         else        check($sformatf("tick_period%0d", k), 32'(cyc - tprev), 32'd10);
         tprev = cyc;
         @(negedge clk);
         do_read(3'd3, rd);
         check($sformatf("data_pop%0d", k), 32'(rd), 32'(exp_s[k]));
      end

      // Fourth tick underruns and holds the last sample
      wait_tick(40);
      check("tick_period3", 32'(cyc - tprev), 32'd10);
      @(negedge clk);
      do_read(3'd0, rd);
      check("status_underrun", 32'(rd), 32'h0015);
      do_read(3'd3, rd);
      check("data_hold", 32'(rd), 32'h0000);
      check("irq_disabled", 32'(irq), 32'h0);
      do_write(3'd1, 16'h0003);
      @(negedge clk);
      check("irq_enabled", 32'(irq), 32'h1);

      // Clear sticky right after a tick; low keeps irq up
      @(negedge clk);
      wait_tick(40);
      @(negedge clk);
      do_write(3'd0, 16'h0001);
      do_read(3'd0, rd);
      check("status_cleared", 32'(rd), 32'h0014);
      check("irq_low_holds", 32'(irq), 32'h1);

      // PWM duty from held samples
      measure_duty(highs);
      check("duty_0000", 32'(highs), 32'd128);
      do_write(3'd3, 16'h7FFF);
      wait_tick(40);
      measure_duty(highs);
      check("duty_7fff", 32'(highs), 32'd255);
      do_write(3'd3, 16'h8000);
      wait_tick(40);
      measure_duty(highs);
      check("duty_8000", 32'(highs), 32'd0);
      do_read(3'd3, rd);
      check("data_8000", 32'(rd), 32'h8000);

      // Stop forces silence; fill to overflow
      do_write(3'd1, 16'h0000);
      do_read(3'd3, rd);
      check("data_stop_zero", 32'(rd), 32'h0000);
      do_write(3'd0, 16'h0000);
      for (int i = 0; i < 65; i++) do_write(3'd3, 16'(i));
      do_read(3'd4, rd);
      check("level_full", 32'(rd), 32'd64);
      do_read(3'd0, rd);
      check("status_overflow", 32'(rd), 32'h000A);

      // Push while full in a tick cycle: pop frees a slot, no overflow
      do_write(3'd0, 16'h0000);
      do_write(3'd2, 16'h0000);
      do_write(3'd1, 16'h0002);
      check("tick_div0", 32'(sample_tick), 32'h1);
      do_write(3'd3, 16'hAAAA);
      do_write(3'd1, 16'h0000);
      do_read(3'd4, rd);
      check("level_full_pushpop", 32'(rd), 32'd64);
      do_read(3'd0, rd);
      check("status_no_overflow", 32'(rd), 32'h0008);

      // Flush, refill to 5, then flush in a tick cycle
      do_write(3'd1, 16'h0004);
      do_read(3'd4, rd);
      check("level_flush", 32'(rd), 32'd0);
      for (int i = 0; i < 5; i++) do_write(3'd3, 16'h0100 + 16'(i));
      do_read(3'd4, rd);
      check("level_5", 32'(rd), 32'd5);
      do_write(3'd1, 16'h0002);
      check("tick_before_flush", 32'(sample_tick), 32'h1);
      do_write(3'd1, 16'h0006);
      do_write(3'd1, 16'h0000);
      do_read(3'd4, rd);
      check("level_flush_tick", 32'(rd), 32'd0);
      do_read(3'd0, rd);
      check("status_flush_tick", 32'(rd), 32'h0014);

      // Reset mid-stream
      do_write(3'd2, 16'd9);
      for (int i = 0; i < 20; i++) do_write(3'd3, 16'h4000 + 16'(i));
      do_write(3'd1, 16'h0003);
      wait_tick(40);
      @(negedge clk);
      do_read(3'd4, rd);
      check("level_before_reset", 32'(rd), 32'd19);
      address = 3'd4;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_readdata", 32'(readdata), 32'h0);
      check("async_irq", 32'(irq), 32'h0);
      check("async_tick", 32'(sample_tick), 32'h0);
      check("async_pwm", 32'(pwm_out), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_reset_table("rereset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
